// File: rtl/rl_fifo_pkg.sv
// Shared types and width helpers for the rl_fifo 1R1W RAM controller.
package rl_fifo_pkg;

    localparam int unsigned ABITS_DEFAULT = 4;

    // Fill count width: holds 0..DEPTH+2 for the given address width.
    function automatic int unsigned cnt_width(input int unsigned abits);
        return abits + 2;
    endfunction

    function automatic int unsigned be_width(input int unsigned dbits);
        return (dbits + 7) / 8;
    endfunction

    typedef logic [ABITS_DEFAULT+1:0] cnt_t;
    typedef logic [1:0]               ob_cnt_t;

endpackage

// File: rtl/rl_fifo_obuf.sv
// Two-entry output register buffer; entry 0 is always the head.
module rl_fifo_obuf
    import rl_fifo_pkg::*;
#(
    parameter int unsigned DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [DBITS-1:0] din_i,
    input  logic             pop_i,
    output ob_cnt_t          cnt_o,
    output logic [DBITS-1:0] head_o
);

    ob_cnt_t          cnt;
    logic [DBITS-1:0] ent0;
    logic [DBITS-1:0] ent1;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din_i;
                    else             ent1 <= din_i;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Pop and refill together: the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        ent0 <= din_i;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_o  = cnt;
    assign head_o = ent0;

endmodule

// File: rtl/rl_fifo_1r1w_ctrl.sv
// FWFT FIFO controller over an external 1R1W RAM with a 2-entry prefetch buffer.
module rl_fifo_1r1w_ctrl
    import rl_fifo_pkg::*;
#(
    parameter int unsigned ABITS     = 4,
    parameter int unsigned DBITS     = 32,
    parameter int unsigned AFULL_LVL = 2**ABITS - 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [DBITS-1:0]             in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [DBITS-1:0]             out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ABITS+1:0]             fill_o,
    output logic                         empty_o,
    output logic                         afull_o,
    output logic [ABITS-1:0]             ram_waddr_o,
    output logic [DBITS-1:0]             ram_din_o,
    output logic                         ram_we_o,
    output logic [be_width(DBITS)-1:0]   ram_be_o,
    output logic [ABITS-1:0]             ram_raddr_o,
    output logic                         ram_re_o,
    input  logic [DBITS-1:0]             ram_dout_i
);

    localparam int unsigned DEPTH = 2**ABITS;
    localparam int unsigned CW    = cnt_width(ABITS);

    logic [ABITS-1:0] wptr;
    logic [ABITS-1:0] rptr;
    logic [ABITS:0]   mem_cnt;
    logic             rd_pend;
    ob_cnt_t          ob_cnt;

    logic             clr;
    logic             push;
    logic             pop;
    logic             rd_issue;
    logic [2:0]       ob_occ;

    always_comb begin
        clr        = rst_i || flush_i;
        in_ready_o = (mem_cnt < (ABITS+1)'(DEPTH));
        push       = in_valid_i && in_ready_o && !clr;
        pop        = out_valid_o && out_ready_i && !clr;
        // Slots the buffer will still need after this cycle's pop; pop implies ob_cnt >= 1.
        ob_occ     = 3'(ob_cnt) + 3'(rd_pend) - 3'(pop);
        rd_issue   = (mem_cnt != '0) && (ob_occ < 3'd2) && !clr;
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push)     wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            mem_cnt <= mem_cnt + (ABITS+1)'(push) - (ABITS+1)'(rd_issue);
            rd_pend <= rd_issue;
        end
    end

    rl_fifo_obuf #(
        .DBITS (DBITS)
    ) u_obuf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .push_i (rd_pend && !clr),
        .din_i  (ram_dout_i),
        .pop_i  (pop),
        .cnt_o  (ob_cnt),
        .head_o (out_data_o)
    );

    always_comb begin
        out_valid_o = (ob_cnt != '0);
        fill_o      = CW'(mem_cnt) + CW'(rd_pend) + CW'(ob_cnt);
        empty_o     = (fill_o == '0);
        afull_o     = (fill_o >= CW'(AFULL_LVL));
        ram_we_o    = push;
        ram_waddr_o = wptr;
        ram_din_o   = in_data_i;
        ram_be_o    = '1;
        ram_re_o    = rd_issue;
        ram_raddr_o = rptr;
    end

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl with a behavioural RAM and a queue scoreboard.
module tb_rl_fifo_1r1w_ctrl;

    localparam int unsigned ABITS = 4;
    localparam int unsigned DBITS = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 14;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic [DBITS-1:0] in_data_i = '0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [DBITS-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [ABITS+1:0] fill_o;
    logic             empty_o, afull_o;
    logic [ABITS-1:0] ram_waddr_o, ram_raddr_o;
    logic [DBITS-1:0] ram_din_o;
    logic [DBITS-1:0] ram_dout_i;
    logic             ram_we_o, ram_re_o;
    logic [3:0]       ram_be_o;

    rl_fifo_1r1w_ctrl #(
        .ABITS     (ABITS),
        .DBITS     (DBITS),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .fill_o      (fill_o),
        .empty_o     (empty_o),
        .afull_o     (afull_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_din_o   (ram_din_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_re_o    (ram_re_o),
        .ram_dout_i  (ram_dout_i)
    );

    always #5 clk = ~clk;

    logic [DBITS-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_waddr_o] <= ram_din_o;
        if (ram_re_o) ram_dout_i <= ram[ram_raddr_o];
    end

    int               vectors = 0;
    int               errors  = 0;
    logic [DBITS-1:0] q [$];
    int               model_fill = 0;

    logic             s_push, s_pop, s_we, s_re, s_valid, s_ready, s_clr;
    logic [ABITS-1:0] s_waddr, s_raddr;
    logic [DBITS-1:0] s_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard, check status after the edge.
    task automatic step();
        @(negedge clk);
        s_push  = in_valid_i && in_ready_o;
        s_pop   = out_valid_o && out_ready_i;
        s_we    = ram_we_o;
        s_re    = ram_re_o;
        s_waddr = ram_waddr_o;
        s_raddr = ram_raddr_o;
        s_valid = out_valid_o;
        s_ready = in_ready_o;
        s_data  = out_data_o;
        s_clr   = rst_i || flush_i;
        if (!s_clr) begin
            if (s_pop) begin
                if (q.size() == 0) chk("pop_on_empty", 64'(q.size()), 64'd1);
                else               chk("pop_data", 64'(s_data), 64'(q.pop_front()));
            end
            if (s_push) q.push_back(in_data_i);
            if (s_we && s_re) chk("rw_collision", 64'(s_waddr != s_raddr), 64'd1);
            model_fill = model_fill + int'(s_push) - int'(s_pop);
        end else begin
            q.delete();
            model_fill = 0;
        end
        @(posedge clk);
        #1;
        chk("fill",  64'(fill_o),  64'(model_fill));
        chk("empty", 64'(empty_o), 64'(model_fill == 0));
        chk("afull", 64'(afull_o), 64'(model_fill >= int'(AFULL)));
    endtask

    initial begin
        int acc, pops, gaps, seen, got;
        logic [DBITS-1:0] d;

        // Reset and idle
        repeat (3) step();
        rst_i = 1'b0;
        step();
        chk("idle_valid", 64'(s_valid), 64'd0);
        chk("idle_ready", 64'(s_ready), 64'd1);
        chk("idle_we",    64'(s_we),    64'd0);
        chk("idle_re",    64'(s_re),    64'd0);
        chk("be_ones",    64'(ram_be_o), 64'hF);

        // Latency of a single push into an empty FIFO
        in_valid_i = 1'b1;
        in_data_i  = 32'hA5A5_0001;
        step();
        chk("lat_we",    64'(s_we),    64'd1);
        chk("lat_waddr", 64'(s_waddr), 64'd0);
        in_valid_i = 1'b0;
        step();
        chk("lat_re",    64'(s_re),    64'd1);
        chk("lat_raddr", 64'(s_raddr), 64'd0);
        chk("lat_nv1",   64'(s_valid), 64'd0);
        step();
        step();
        chk("lat_valid", 64'(s_valid), 64'd1);
        chk("lat_data",  64'(s_data),  64'hA5A5_0001);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

        // Fill to full with the consumer stalled
        acc = 0;
        for (int i = 1; i <= 20; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'(i);
            step();
            if (s_push) acc++;
            if (i == 20) chk("full_ready", 64'(s_ready), 64'd0);
        end
        in_valid_i = 1'b0;
        chk("full_accepted", 64'(acc), 64'd18);
        chk("full_fill",     64'(fill_o), 64'd18);
        out_ready_i = 1'b1;
        pops = 0;
        for (int k = 0; k < 60 && q.size() != 0; k++) begin
            step();
            if (s_pop) pops++;
        end
        chk("full_pops", 64'(pops), 64'd18);
        out_ready_i = 1'b0;

        // Streaming, wrapping both pointers
        d = 32'h1000;
        pops = 0; gaps = 0; seen = 0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data_i = d;
            step();
            if (s_push) d++;
            if (s_pop) begin
                pops++;
                seen = 1;
            end else if (seen != 0) begin
                gaps++;
            end
        end
        chk("stream_gaps", 64'(gaps), 64'd0);
        chk("stream_pops", 64'(pops), 64'd97);
        in_valid_i = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("stream_drain", 64'(q.size()), 64'd0);

        // Random backpressure on both sides
        for (int k = 0; k < 2000; k++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = $urandom;
            out_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 40 && q.size() != 0; k++) step();
        chk("rand_drain", 64'(q.size()), 64'd0);
        out_ready_i = 1'b0;

        // Flush with a RAM read in flight
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h50 + 32'(i);
            step();
        end
        in_valid_i = 1'b0;
        repeat (3) step();
        in_valid_i  = 1'b1;
        in_data_i   = 32'h55;
        out_ready_i = 1'b1;
        step();
        chk("flush_re",   64'(s_re),   64'd1);
        chk("flush_fill5", 64'(fill_o), 64'd5);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_fill0", 64'(fill_o), 64'd0);
        step();
        chk("flush_nv", 64'(s_valid), 64'd0);
        in_valid_i = 1'b1;
        in_data_i  = 32'h77;
        step();
        in_valid_i = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            step();
            if (s_valid) got = 1;
        end
        chk("flush_got",  64'(got),    64'd1);
        chk("flush_data", 64'(s_data), 64'h77);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        step();
        chk("final_empty", 64'(empty_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
